ram1_fetch_arbiter: RTL and testbench



---
 rtl/ram1_fetch_arbiter.sv | 121 ++++++++++++
 tb/tb_ram1_fetch_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ram1_fetch_arbiter.sv
// ram1_fetch_arbiter: shares the RAM1/serial bus between instruction fetch and MEM-stage data accesses.
// Optional IFETCH_HITBUF_EN adds a one-entry fetch hit buffer that skips the RAM access on a repeated pc.
module ram1_fetch_arbiter #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16,
    parameter int WAIT_STATES = 1,
    parameter logic [DATA_W-1:0] NOP_WORD = 16'h0800,
    parameter logic [15:0] RAM1_UPPER = 16'h8000,
    parameter logic [15:0] IO_BASE = 16'hBF00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [15:0]       fetch_pc,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic              mem_conflict,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [15:0]       dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_done,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              io_grant,
    output logic              busy,
    output logic [ADDR_W-1:0] ram1_addr,
    inout  wire  [DATA_W-1:0] ram1_data,
    output logic              ram1_en,
    output logic              ram1_oe,
    output logic              ram1_we
);
    typedef enum logic [1:0] {IDLE, SETUP, ACTIVE, LAST} state_t;
    typedef enum logic [2:0] {K_FETCH, K_RD, K_WR, K_IO, K_HIT} kind_t;
    localparam logic [2:0] WS_LAST = 3'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);

    state_t state, state_n;
    kind_t kind, kind_n;
    logic [15:0] addr_q;
    logic [DATA_W-1:0] wdata_q, instr_q, rdata_q, hit_word;
    logic [2:0] cnt;
    logic fetch_q, start, hit, dm_any, is_ram, is_io, last;

`ifdef IFETCH_HITBUF_EN
    logic [15:0] hb_pc;
    logic [DATA_W-1:0] hb_word;
    logic hb_valid;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hb_valid <= 1'b0;
            hb_pc <= '0;
            hb_word <= '0;
        end else if (state == IDLE && start && kind_n == K_WR) begin
            hb_valid <= 1'b0;
        end else if (last && kind == K_FETCH) begin
            hb_valid <= 1'b1;
            hb_pc <= addr_q;
            hb_word <= ram1_data;
        end
    end
    assign hit = hb_valid && fetch_pc == hb_pc;
    assign hit_word = hb_word;
`else
    assign hit = 1'b0;
    assign hit_word = NOP_WORD;
`endif

    always_comb begin
        dm_any = dm_read | dm_write;
        is_ram = dm_any && dm_addr < RAM1_UPPER;
        is_io = dm_any && dm_addr[15:2] == IO_BASE[15:2];
        kind_n = is_ram ? (dm_write ? K_WR : K_RD) : is_io ? K_IO : hit ? K_HIT : K_FETCH;
        start = is_ram || is_io || fetch_req;
        state_n = state;
        case (state)
            IDLE:    state_n = !start ? IDLE : kind_n == K_HIT ? LAST : SETUP;
            SETUP:   state_n = WAIT_STATES == 0 ? LAST : ACTIVE;
            ACTIVE:  state_n = cnt == WS_LAST ? LAST : ACTIVE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            kind <= K_FETCH;
            addr_q <= '0;
            wdata_q <= '0;
            instr_q <= NOP_WORD;
            rdata_q <= '0;
            cnt <= '0;
            fetch_q <= 1'b0;
            mem_conflict <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= state == ACTIVE ? cnt + 3'd1 : 3'd0;
            if (state == IDLE && start) begin
                kind <= kind_n;
                addr_q <= (is_ram || is_io) ? dm_addr : fetch_pc;
                wdata_q <= dm_wdata;
                fetch_q <= fetch_req;
                mem_conflict <= fetch_req && (is_ram || is_io);
            end
            if (instr_valid) instr_q <= instr;
            if (last && kind == K_RD) rdata_q <= ram1_data;
        end
    end

    assign last = state == LAST;
    assign busy = state != IDLE;
    assign io_grant = busy && kind == K_IO;
    assign ram1_addr = ADDR_W'(addr_q);
    assign ram1_en = !(busy && kind inside {K_FETCH, K_RD, K_WR});
    assign ram1_oe = !(busy && kind inside {K_FETCH, K_RD});
    assign ram1_we = !(state == ACTIVE && kind == K_WR);
    assign ram1_data = (busy && kind == K_WR) ? wdata_q : 'z;
    // Results are presented combinationally in LAST and held in registers afterwards.
    assign instr_valid = last && fetch_q;
    assign instr = !instr_valid ? instr_q : kind == K_FETCH ? ram1_data : kind == K_HIT ? hit_word : NOP_WORD;
    assign dm_done = last && kind inside {K_RD, K_WR};
    assign dm_rdata = (last && kind == K_RD) ? ram1_data : rdata_q;
endmodule

// File: tb/tb_ram1_fetch_arbiter.sv
// tb_ram1_fetch_arbiter: directed scoreboard bench for ram1_fetch_arbiter (WAIT_STATES=1, plus a WAIT_STATES=0 twin).
module tb_ram1_fetch_arbiter;
    logic clk = 1'b0, rst = 1'b1;
    logic fetch_req = 1'b0, dm_read = 1'b0, dm_write = 1'b0;
    logic [15:0] fetch_pc = '0, dm_addr = '0, dm_wdata = '0;
    logic instr_valid, mem_conflict, dm_done, io_grant, busy, ram1_en, ram1_oe, ram1_we;
    logic [15:0] instr, dm_rdata;
    logic [17:0] ram1_addr;
    wire [15:0] ram1_data;
    logic instr0_valid, mem_conflict0, dm_done0, io_grant0, busy0, ram0_en, ram0_oe, ram0_we;
    logic [15:0] instr0, dm_rdata0;
    logic [17:0] ram0_addr;
    wire [15:0] ram0_data;
    logic [15:0] mem [64];
    logic [16:0] exp_i[$], exp_d[$];
    int n_chk = 0, n_pass = 0;
    int lat_v, lat_d, lat_v0, we_lo, en_lo, io_n, done_n, slot_n;
    logic [15:0] word0;

    always #5 clk = ~clk;

    ram1_fetch_arbiter #(.WAIT_STATES(1)) dut (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_pc(fetch_pc), .instr_valid(instr_valid),
        .instr(instr), .mem_conflict(mem_conflict), .dm_read(dm_read), .dm_write(dm_write),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_done(dm_done), .dm_rdata(dm_rdata),
        .io_grant(io_grant), .busy(busy), .ram1_addr(ram1_addr), .ram1_data(ram1_data),
        .ram1_en(ram1_en), .ram1_oe(ram1_oe), .ram1_we(ram1_we));

    ram1_fetch_arbiter #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_pc(fetch_pc), .instr_valid(instr0_valid),
        .instr(instr0), .mem_conflict(mem_conflict0), .dm_read(dm_read), .dm_write(dm_write),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_done(dm_done0), .dm_rdata(dm_rdata0),
        .io_grant(io_grant0), .busy(busy0), .ram1_addr(ram0_addr), .ram1_data(ram0_data),
        .ram1_en(ram0_en), .ram1_oe(ram0_oe), .ram1_we(ram0_we));

    // Small asynchronous SRAM model: the few test addresses map to distinct entries.
    assign ram1_data = (!ram1_en && !ram1_oe) ? mem[{ram1_addr[13:12], ram1_addr[3:0]}] : 16'hzzzz;
    assign ram0_data = (!ram0_en && !ram0_oe) ? mem[{ram0_addr[13:12], ram0_addr[3:0]}] : 16'hzzzz;
    always @(posedge ram1_we) if (!ram1_en) mem[{ram1_addr[13:12], ram1_addr[3:0]}] = ram1_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        logic [16:0] e;
        if (instr_valid) begin
            if (exp_i.size() == 0) chk("instr_unexpected", 32'd1, 32'd0);
            else begin
                e = exp_i.pop_front();
                chk("instr", 32'(instr), 32'(e[15:0]));
                chk("instr_conflict", 32'(mem_conflict), 32'(e[16]));
            end
        end
        if (dm_done) begin
            if (exp_d.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
            else begin
                e = exp_d.pop_front();
                if (e[16]) chk("dm_rdata", 32'(dm_rdata), 32'(e[15:0]));
            end
        end
    end

    task automatic pulse_req(input logic f, input logic [15:0] pc, input logic r, input logic w,
                             input logic [15:0] a, input logic [15:0] d);
        fetch_req = f; fetch_pc = pc; dm_read = r; dm_write = w; dm_addr = a; dm_wdata = d;
        @(negedge clk);
        fetch_req = 0; dm_read = 0; dm_write = 0; dm_addr = 16'hFFFF; dm_wdata = 16'h0;
    endtask

    task automatic run_slot();
        int n = 1;
        lat_v = 0; lat_d = 0; lat_v0 = 0; we_lo = 0; en_lo = 0; io_n = 0; done_n = 0; word0 = 'x;
        while (busy && n < 20) begin
            if (instr_valid && lat_v == 0) lat_v = n;
            if (dm_done && lat_d == 0) lat_d = n;
            if (instr0_valid && lat_v0 == 0) begin lat_v0 = n; word0 = instr0; end
            if (!ram1_we) we_lo++;
            if (!ram1_en) en_lo++;
            if (io_grant) io_n++;
            if (dm_done) done_n++;
            @(negedge clk);
            n++;
        end
        slot_n = n - 1;
        if (busy) chk("slot_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h0;
        mem[4] = 16'h4A05; mem[6] = 16'h5A5A; mem[32] = 16'h1234;
        repeat (2) @(negedge clk);
        chk("rst_en", 32'(ram1_en), 32'd1);
        chk("rst_oe", 32'(ram1_oe), 32'd1);
        chk("rst_we", 32'(ram1_we), 32'd1);
        chk("rst_addr", 32'(ram1_addr), 32'd0);
        chk("rst_instr", 32'(instr), 32'h0800);
        chk("rst_rdata", 32'(dm_rdata), 32'd0);
        chk("rst_flags", {27'd0, instr_valid, dm_done, mem_conflict, io_grant, busy}, 32'd0);
        rst = 0;
        @(negedge clk);
        // plain fetch
        exp_i.push_back({1'b0, 16'h4A05});
        pulse_req(1, 16'h0004, 0, 0, 16'h0, 16'h0);
        chk("fetch_addr", 32'(ram1_addr), 32'h00004);
        chk("fetch_oe", {30'd0, ram1_oe, ram1_en}, 32'd0);
        run_slot();
        chk("fetch_lat", lat_v, 3);
        chk("fetch_slot", slot_n, 3);
        chk("instr_held", 32'(instr), 32'h4A05);
        // write then read back
        exp_d.push_back({1'b0, 16'h0});
        pulse_req(0, 16'h0, 0, 1, 16'h1000, 16'hBEEF);
        chk("wr_setup_we", 32'(ram1_we), 32'd1);
        chk("wr_setup_data", 32'(ram1_data), 32'hBEEF);
        run_slot();
        chk("wr_we_low", we_lo, 1);
        chk("wr_done", done_n, 1);
        exp_d.push_back({1'b1, 16'hBEEF});
        pulse_req(0, 16'h0, 1, 0, 16'h1000, 16'h0);
        run_slot();
        chk("rd_done", done_n, 1);
        chk("rd_we_low", we_lo, 0);
        // fetch colliding with IO access
        exp_i.push_back({1'b1, 16'h0800});
        pulse_req(1, 16'h0004, 1, 0, 16'hBF01, 16'h0);
        chk("io_conflict", 32'(mem_conflict), 32'd1);
        chk("io_strobes", {29'd0, ram1_en, ram1_oe, ram1_we}, 32'h7);
        run_slot();
        chk("io_grant_n", io_n, 3);
        chk("io_no_done", done_n, 0);
        chk("io_en_low", en_lo, 0);
        chk("io_nop_lat", lat_v, 3);
        // fetch colliding with RAM1 read
        exp_i.push_back({1'b1, 16'h0800});
        exp_d.push_back({1'b1, 16'h1234});
        pulse_req(1, 16'h0004, 1, 0, 16'h2000, 16'h0);
        run_slot();
        chk("cf_done_lat", lat_d, 3);
        chk("cf_valid_lat", lat_v, 3);
        chk("cf_conflict_held", 32'(mem_conflict), 32'd1);
        exp_i.push_back({1'b0, 16'h5A5A});
        pulse_req(1, 16'h0006, 0, 0, 16'h0, 16'h0);
        chk("conflict_cleared", 32'(mem_conflict), 32'd0);
        run_slot();
        // reset in the middle of a write
        pulse_req(0, 16'h0, 0, 1, 16'h1000, 16'h7777);
        @(negedge clk);
        chk("ab_active_we", 32'(ram1_we), 32'd0);
        #1 rst = 1;
        #1;
        chk("ab_we_en", {30'd0, ram1_we, ram1_en}, 32'd3);
        chk("ab_pulses", {29'd0, instr_valid, dm_done, busy}, 32'd0);
        @(negedge clk);
        rst = 0;
        chk("ab_instr", 32'(instr), 32'h0800);
        @(negedge clk);
        // zero-wait-state twin completes a fetch in two cycles
        exp_i.push_back({1'b0, 16'h5A5A});
        pulse_req(1, 16'h0006, 0, 0, 16'h0, 16'h0);
        run_slot();
        chk("ws0_lat", lat_v0, 2);
        chk("ws0_word", 32'(word0), 32'h5A5A);
        chk("ws1_lat", lat_v, 3);
`ifdef IFETCH_HITBUF_EN
        exp_i.push_back({1'b0, 16'h5A5A});
        pulse_req(1, 16'h0006, 0, 0, 16'h0, 16'h0);
        run_slot();
        chk("hit_lat", lat_v, 1);
        chk("hit_no_strobe", en_lo, 0);
        exp_d.push_back({1'b0, 16'h0});
        pulse_req(0, 16'h0, 0, 1, 16'h2000, 16'h1111);
        run_slot();
        exp_i.push_back({1'b0, 16'h5A5A});
        pulse_req(1, 16'h0006, 0, 0, 16'h0, 16'h0);
        run_slot();
        chk("miss_after_wr_lat", lat_v, 3);
`endif
        repeat (2) @(negedge clk);
        chk("instr_q_empty", exp_i.size(), 0);
        chk("done_q_empty", exp_d.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
